// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state encodings,
// opcode constants, mux select codes and the control-word layout.
package mc_ctrl_pkg;

    localparam int OPW_DEF    = 6;
    localparam int STATEW_DEF = 4;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWR    = 4'd4,
        MEMWB    = 4'd5,
        EXEC_R   = 4'd6,
        RTYPE_WB = 4'd7,
        EXEC_I   = 4'd8,
        ITYPE_WB = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_REGB   = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

    // Everything the FSM drives into the datapath except illegal_op.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    // True for every opcode the DECODE step knows how to dispatch.
    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word table. Pure Moore decode; the
// mem_ready qualification and reset gating live in the top module.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Per-state control word; unused encodings fall to the all-zero default.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH2;
                ctrl.alu_op    = ALU_ADD;
            end
            MEMADR, EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALU_FUNCT;
            end
            RTYPE_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ITYPE_WB: begin
                ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle datapath: state register, next-state
// logic, mem_ready qualification of the fetch enables and reset gating.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int STATEW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    opcode,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              mem_to_reg,
    output logic [1:0]        pc_source,
    output logic [1:0]        alu_op,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              illegal_op,
    output logic [STATEW-1:0] state
);

    state_t     state_reg;
    state_t     state_next;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl_out;
    logic [5:0] op;

    assign op = 6'(opcode);

    mc_ctrl_decode u_decode (
        .state (state_reg),
        .ctrl  (ctrl_raw)
    );

    // State register; reset abandons whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= FETCH;
        else        state_reg <= state_next;
    end

    // Next-state: opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:    state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) state_next = MEMADR;
                else if (op == OP_RTYPE)        state_next = EXEC_R;
                else if (op == OP_BEQ)          state_next = BRANCH;
                else if (op == OP_J)            state_next = JUMP;
                else if (op == OP_ADDI)         state_next = EXEC_I;
                else                            state_next = FETCH;
            end
            MEMADR:   state_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    state_next = mem_ready ? MEMWB : MEMRD;
            MEMWR:    state_next = mem_ready ? FETCH : MEMWR;
            MEMWB:    state_next = FETCH;
            EXEC_R:   state_next = RTYPE_WB;
            RTYPE_WB: state_next = FETCH;
            EXEC_I:   state_next = ITYPE_WB;
            ITYPE_WB: state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JUMP:     state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // IR/PC load in FETCH only when the read completes; everything is
    // silenced while reset is held so nothing is written on that cycle.
    always_comb begin
        ctrl_out = ctrl_raw;
        if (state_reg == FETCH) begin
            ctrl_out.ir_write = ctrl_raw.ir_write & mem_ready;
            ctrl_out.pc_write = ctrl_raw.pc_write & mem_ready;
        end
        if (!rst_n) ctrl_out = '0;
    end

    assign illegal_op    = rst_n && (state_reg == DECODE) && !is_supported(op);
    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign i_or_d        = ctrl_out.i_or_d;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign pc_source     = ctrl_out.pc_source;
    assign alu_op        = ctrl_out.alu_op;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign reg_write     = ctrl_out.reg_write;
    assign reg_dst       = ctrl_out.reg_dst;
    assign state         = STATEW'(state_reg);

endmodule
